// File: rtl/act_quant_pack.sv
// Requant/pack stage: ReLU, rounding shift and int8 saturation, then two beats packed per RAM word.
// Latency: write 2 cycles after the second beat of a pair; no backpressure, beats taken whenever RUN.
module act_quant_pack #(
  parameter int LANES          = 32,
  parameter int IN_W           = 16,
  parameter int OUT_W          = 8,
  parameter int RAM_ADDR_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_calc_en,
  input  logic                        i_relu_en,
  input  logic [3:0]                  i_shift,
  input  logic [RAM_ADDR_WIDTH-1:0]   i_addr_start_o,
  input  logic [LANES*IN_W-1:0]       i_bias_dat,
  input  logic                        i_bias_dat_vld,
  input  logic                        i_calculate_end,
  output logic                        o_ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [2*LANES*OUT_W-1:0]    o_ram_dat,
  output logic                        o_done
);

  localparam int SW     = IN_W + 1;
  localparam int HALF_W = LANES * OUT_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic       relu;
    logic [3:0] shift;
  } cfg_t;

  state_t                      state_q, state_d;
  cfg_t                        cfg_q;
  logic [RAM_ADDR_WIDTH-1:0]   addr_q;
  logic                        half_q;
  logic                        s1_vld_q;
  logic [HALF_W-1:0]           s1_q;
  logic [HALF_W-1:0]           low_q;
  logic [HALF_W-1:0]           q_nxt;
  logic                        accept;
  logic                        flush_wr;

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x,
                                             input logic relu, input logic [3:0] sh);
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] y;
    logic signed [SW-1:0] smax;
    logic signed [SW-1:0] smin;
    smax = SW'((2 ** (OUT_W - 1)) - 1);
    smin = ~smax;
    r = (relu && x[IN_W-1]) ? '0 : SW'(x);
    if (sh != 4'd0) r = r + (SW'(1) << (sh - 4'd1));
    y = r >>> sh;
    if (y > smax)      quant = smax[OUT_W-1:0];
    else if (y < smin) quant = smin[OUT_W-1:0];
    else               quant = y[OUT_W-1:0];
  endfunction

  always_comb begin
    q_nxt = '0;
    for (int k = 0; k < LANES; k++)
      q_nxt[k*OUT_W +: OUT_W] = quant(i_bias_dat[k*IN_W +: IN_W], cfg_q.relu, cfg_q.shift);
  end

  assign accept   = i_bias_dat_vld && (state_q == S_RUN) && !i_calc_en;
  assign flush_wr = (state_q == S_FLUSH) && !s1_vld_q && half_q && !i_calc_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE:  if (i_calc_en) state_d = S_RUN;
      S_RUN: begin
        if (i_calc_en)            state_d = S_RUN;
        else if (i_calculate_end) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (i_calc_en)                 state_d = S_RUN;
        else if (!s1_vld_q && !half_q) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = i_calc_en ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cfg_q       <= '0;
      addr_q      <= '0;
      half_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_q        <= '0;
      low_q       <= '0;
      o_ram_wr_en <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_dat   <= '0;
    end else begin
      o_ram_wr_en <= 1'b0;
      if (i_calc_en) begin
        // Restart drops any half-filled word and in-flight beat.
        cfg_q    <= '{relu: i_relu_en, shift: i_shift};
        addr_q   <= i_addr_start_o;
        half_q   <= 1'b0;
        s1_vld_q <= 1'b0;
      end else begin
        s1_vld_q <= accept;
        if (accept) s1_q <= q_nxt;
        if (s1_vld_q) begin
          if (!half_q) begin
            low_q  <= s1_q;
            half_q <= 1'b1;
          end else begin
            o_ram_wr_en <= 1'b1;
            o_ram_addr  <= addr_q;
            o_ram_dat   <= {s1_q, low_q};
            addr_q      <= addr_q + 1'b1;
            half_q      <= 1'b0;
          end
        end else if (flush_wr) begin
          o_ram_wr_en <= 1'b1;
          o_ram_addr  <= addr_q;
          o_ram_dat   <= {{HALF_W{1'b0}}, low_q};
          addr_q      <= addr_q + 1'b1;
          half_q      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_quant_pack.sv
// Directed bench for act_quant_pack: lane arithmetic vectors plus pack/flush/reset sequences.
module tb_act_quant_pack;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_calc_en;
  logic         i_relu_en;
  logic [3:0]   i_shift;
  logic [7:0]   i_addr_start_o;
  logic [511:0] i_bias_dat;
  logic         i_bias_dat_vld;
  logic         i_calculate_end;
  logic         o_ram_wr_en;
  logic [7:0]   o_ram_addr;
  logic [511:0] o_ram_dat;
  logic         o_done;

  act_quant_pack dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_calc_en(i_calc_en), .i_relu_en(i_relu_en),
    .i_shift(i_shift), .i_addr_start_o(i_addr_start_o), .i_bias_dat(i_bias_dat),
    .i_bias_dat_vld(i_bias_dat_vld), .i_calculate_end(i_calculate_end),
    .o_ram_wr_en(o_ram_wr_en), .o_ram_addr(o_ram_addr), .o_ram_dat(o_ram_dat), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [7:0]   addr;
    logic [511:0] dat;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  ncmp = 0;
  int  nerr = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_ram_wr_en) wq.push_back('{cyc, o_ram_addr, o_ram_dat});
    if (o_done) begin
      dq.push_back(cyc);
      chk("done_without_write", 512'(o_ram_wr_en), 512'd0);
    end
  end

  typedef struct {
    logic            relu;
    logic [3:0]      sh;
    logic [3:0][15:0] x;
    logic [3:0][7:0]  e;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [511:0] mk_beat(input logic [3:0][15:0] x, input int rot);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b[16*k +: 16] = x[(k + rot) % 4];
    return b;
  endfunction

  function automatic logic [255:0] mk_half(input logic [3:0][7:0] e, input int rot);
    logic [255:0] h;
    h = '0;
    for (int k = 0; k < 32; k++) h[8*k +: 8] = e[(k + rot) % 4];
    return h;
  endfunction

  function automatic logic [511:0] cbeat(input logic [15:0] v);
    return {32{v}};
  endfunction

  function automatic logic [255:0] chalf(input logic [7:0] v);
    return {32{v}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic relu, input logic [3:0] sh, input logic [7:0] a);
    i_calc_en = 1'b1; i_relu_en = relu; i_shift = sh; i_addr_start_o = a;
    tick();
    i_calc_en = 1'b0;
  endtask

  task automatic beat(input logic [511:0] d, output int c);
    i_bias_dat = d; i_bias_dat_vld = 1'b1; c = cyc;
    tick();
    i_bias_dat_vld = 1'b0;
  endtask

  task automatic end_pulse();
    i_calculate_end = 1'b1;
    tick();
    i_calculate_end = 1'b0;
  endtask

  task automatic clearq();
    wq.delete();
    dq.delete();
  endtask

  initial begin
    int c[4];
    vecs[0] = '{1'b1, 4'd0,  {16'hFED4, 16'h012C, 16'h0064, 16'hFFFB}, {8'h00, 8'h7F, 8'h64, 8'h00}};
    vecs[1] = '{1'b0, 4'd4,  {16'h8000, 16'hFFE8, 16'h0017, 16'h0018}, {8'h80, 8'hFF, 8'h01, 8'h02}};
    vecs[2] = '{1'b0, 4'd0,  {16'hFF7F, 16'hFF80, 16'h0080, 16'h007F}, {8'h80, 8'h80, 8'h7F, 8'h7F}};
    vecs[3] = '{1'b0, 4'd1,  {16'h00FF, 16'hFFFF, 16'hFFFD, 16'h0003}, {8'h7F, 8'h00, 8'hFF, 8'h02}};
    vecs[4] = '{1'b1, 4'd15, {16'hFFFF, 16'h3FFF, 16'h4000, 16'h7FFF}, {8'h00, 8'h00, 8'h01, 8'h01}};
    vecs[5] = '{1'b0, 4'd8,  {16'h0080, 16'hFF7F, 16'h7FFF, 16'h8000}, {8'h01, 8'hFF, 8'h7F, 8'h80}};
    vecs[6] = '{1'b1, 4'd2,  {16'h8000, 16'h0005, 16'h0006, 16'hFFFF}, {8'h00, 8'h01, 8'h02, 8'h00}};

    i_rst_n = 1'b0; i_calc_en = 1'b0; i_relu_en = 1'b0; i_shift = 4'd0;
    i_addr_start_o = 8'd0; i_bias_dat = '0; i_bias_dat_vld = 1'b0; i_calculate_end = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", 512'(o_ram_wr_en), 512'd0);
    chk("rst_addr",  512'(o_ram_addr),  512'd0);
    chk("rst_dat",   o_ram_dat,         512'd0);
    chk("rst_done",  512'(o_done),      512'd0);
    i_rst_n = 1'b1;
    tick();

    // Lane arithmetic: two beats per vector, second beat rotated to check half placement.
    for (int i = 0; i < 7; i++) begin
      clearq();
      start(vecs[i].relu, vecs[i].sh, 8'h40 + 8'(i));
      beat(mk_beat(vecs[i].x, 0), c[0]);
      beat(mk_beat(vecs[i].x, 1), c[1]);
      end_pulse();
      repeat (6) tick();
      chk($sformatf("v%0d_nwr", i), 512'(wq.size()), 512'd1);
      chk($sformatf("v%0d_ndone", i), 512'(dq.size()), 512'd1);
      if (wq.size() > 0) begin
        chk($sformatf("v%0d_addr", i), 512'(wq[0].addr), 512'(8'h40 + 8'(i)));
        chk($sformatf("v%0d_dat", i), wq[0].dat, {mk_half(vecs[i].e, 1), mk_half(vecs[i].e, 0)});
        chk($sformatf("v%0d_lat", i), 512'(wq[0].cyc), 512'(c[1] + 2));
      end
    end

    // Four back-to-back beats: two writes, each two cycles after its pair completes.
    clearq();
    start(1'b0, 4'd0, 8'h10);
    for (int j = 0; j < 4; j++) beat(cbeat(16'(j + 1)), c[j]);
    repeat (6) tick();
    chk("b2b_nwr", 512'(wq.size()), 512'd2);
    if (wq.size() == 2) begin
      chk("b2b_addr0", 512'(wq[0].addr), 512'h10);
      chk("b2b_addr1", 512'(wq[1].addr), 512'h11);
      chk("b2b_lat0",  512'(wq[0].cyc),  512'(c[1] + 2));
      chk("b2b_lat1",  512'(wq[1].cyc),  512'(c[3] + 2));
      chk("b2b_dat0",  wq[0].dat, {chalf(8'h02), chalf(8'h01)});
      chk("b2b_dat1",  wq[1].dat, {chalf(8'h04), chalf(8'h03)});
    end
    end_pulse();
    repeat (5) tick();
    chk("b2b_nwr_after_end", 512'(wq.size()), 512'd2);
    chk("b2b_ndone", 512'(dq.size()), 512'd1);

    // Odd beat count: flush writes the lone half with a zero upper half.
    clearq();
    start(1'b0, 4'd0, 8'h20);
    for (int j = 0; j < 3; j++) beat(cbeat(16'(j + 1)), c[j]);
    end_pulse();
    repeat (8) tick();
    chk("flush_nwr", 512'(wq.size()), 512'd2);
    chk("flush_ndone", 512'(dq.size()), 512'd1);
    if (wq.size() == 2 && dq.size() == 1) begin
      chk("flush_addr0", 512'(wq[0].addr), 512'h20);
      chk("flush_dat0",  wq[0].dat, {chalf(8'h02), chalf(8'h01)});
      chk("flush_addr1", 512'(wq[1].addr), 512'h21);
      chk("flush_dat1",  wq[1].dat, {256'd0, chalf(8'h03)});
      chk("flush_done_lat", 512'(dq[0]), 512'(wq[1].cyc + 1));
    end

    // Address wrap.
    clearq();
    start(1'b0, 4'd0, 8'hFF);
    for (int j = 0; j < 4; j++) beat(cbeat(16'(j + 5)), c[j]);
    end_pulse();
    repeat (6) tick();
    chk("wrap_nwr", 512'(wq.size()), 512'd2);
    if (wq.size() == 2) begin
      chk("wrap_addr0", 512'(wq[0].addr), 512'hFF);
      chk("wrap_addr1", 512'(wq[1].addr), 512'h00);
      chk("wrap_dat1",  wq[1].dat, {chalf(8'h08), chalf(8'h07)});
    end

    // Reset mid-run: the half-filled word vanishes and no done follows.
    clearq();
    start(1'b0, 4'd0, 8'h30);
    beat(cbeat(16'h0011), c[0]);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_mid_nwr", 512'(wq.size()), 512'd0);
    chk("rst_mid_ndone", 512'(dq.size()), 512'd0);
    chk("rst_mid_dat", o_ram_dat, 512'd0);
    start(1'b0, 4'd0, 8'h50);
    beat(cbeat(16'h0021), c[0]);
    beat(cbeat(16'h0022), c[1]);
    end_pulse();
    repeat (6) tick();
    chk("rerun_nwr", 512'(wq.size()), 512'd1);
    if (wq.size() == 1) begin
      chk("rerun_addr", 512'(wq[0].addr), 512'h50);
      chk("rerun_dat",  wq[0].dat, {chalf(8'h22), chalf(8'h21)});
    end

    // Restart while half full: the stale half is dropped, not written.
    clearq();
    start(1'b0, 4'd0, 8'h60);
    beat(cbeat(16'h0009), c[0]);
    start(1'b0, 4'd0, 8'h70);
    beat(cbeat(16'h0031), c[0]);
    beat(cbeat(16'h0032), c[1]);
    end_pulse();
    repeat (6) tick();
    chk("restart_nwr", 512'(wq.size()), 512'd1);
    if (wq.size() == 1) begin
      chk("restart_addr", 512'(wq[0].addr), 512'h70);
      chk("restart_dat",  wq[0].dat, {chalf(8'h32), chalf(8'h31)});
    end
    chk("hold_dat", o_ram_dat, {chalf(8'h32), chalf(8'h31)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
